// File: rtl/strobe_gen_pkg.sv
// Shared types and constants for the strobe generator.
// Optional feature macro: STROBE_GEN_TICK_CNT_EN (per-channel tick counters).
package strobe_gen_pkg;

  // Configuration word width used by the packed config record; the top
  // carries the runtime divisor at its own DIV_W.
  localparam int PKG_DIV_W = 16;

  // Divisor value that parks a channel (no ticks).
  localparam int DIV_IDLE = 0;

  // Width of each per-channel tick counter.
  localparam int TICK_CNT_W = 8;

  typedef struct packed {
    logic                 en;
    logic [PKG_DIV_W-1:0] div;
  } ch_cfg_t;

endpackage

// File: rtl/strobe_gen_if.sv
// Configuration port of the strobe generator (valid/ready write channel).
interface strobe_gen_if #(
  parameter int NUM_CH = 4,
  parameter int DIV_W  = 16
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic             cfg_en;
  logic [DIV_W-1:0] cfg_div;

  modport master (output cfg_valid, output cfg_ch, output cfg_en, output cfg_div,
                  input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_en, input cfg_div,
                  output cfg_ready);
endinterface

// File: rtl/strobe_gen_ch.sv
// One strobe channel: down-counter, shadow config and pending flag.
// With STROBE_GEN_TICK_CNT_EN defined, tick_set flags the edge that raises tick.
module strobe_gen_ch
  import strobe_gen_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int RST_DIV = 0,
  parameter int RST_EN  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_wr,
  input  logic             cfg_en,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             sync,
  output logic             tick,
  output logic             busy
`ifdef STROBE_GEN_TICK_CNT_EN
  ,
  output logic             tick_set
`endif
);

  logic             en_q, en_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             sh_en_q, sh_en_d;
  logic [DIV_W-1:0] sh_div_q, sh_div_d;
  logic             tick_q, tick_d;
  logic             active;

  // Counter start value for a freshly applied config (0 when parked).
  function automatic logic [DIV_W-1:0] reload(input logic en, input logic [DIV_W-1:0] div);
    return (en && (div != DIV_W'(DIV_IDLE))) ? div - DIV_W'(1) : '0;
  endfunction

  // A channel only "runs" with a non-zero divisor; a parked channel with
  // en=1, div=0 takes new config immediately since it never reaches a
  // terminal count.
  assign active = en_q && (div_q != DIV_W'(DIV_IDLE));

  // Next-state: immediate config, sync realign, count/terminal handling.
  always_comb begin
    en_d     = en_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    pend_d   = pend_q;
    sh_en_d  = sh_en_q;
    sh_div_d = sh_div_q;
    tick_d   = 1'b0;
    if (cfg_wr && (!active || sync)) begin
      en_d  = cfg_en;
      div_d = cfg_div;
      cnt_d = reload(cfg_en, cfg_div);
    end else if (sync) begin
      if (pend_q) begin
        en_d   = sh_en_q;
        div_d  = sh_div_q;
        cnt_d  = reload(sh_en_q, sh_div_q);
        pend_d = 1'b0;
      end else if (active) begin
        cnt_d = div_q - DIV_W'(1);
      end
    end else if (active) begin
      if (cnt_q == '0) begin
        tick_d = 1'b1;
        if (pend_q) begin
          en_d   = sh_en_q;
          div_d  = sh_div_q;
          cnt_d  = reload(sh_en_q, sh_div_q);
          pend_d = 1'b0;
        end else begin
          cnt_d = div_q - DIV_W'(1);
        end
      end else begin
        cnt_d = cnt_q - DIV_W'(1);
      end
      // Accept at terminal count still ticks with the old divisor; the new
      // value waits for the following terminal count.
      if (cfg_wr) begin
        sh_en_d  = cfg_en;
        sh_div_d = cfg_div;
        pend_d   = 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q     <= (RST_EN != 0);
      div_q    <= DIV_W'(RST_DIV);
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      sh_en_q  <= 1'b0;
      sh_div_q <= '0;
      tick_q   <= 1'b0;
    end else begin
      en_q     <= en_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      sh_en_q  <= sh_en_d;
      sh_div_q <= sh_div_d;
      tick_q   <= tick_d;
    end
  end

  assign tick = tick_q;
  assign busy = pend_q;
`ifdef STROBE_GEN_TICK_CNT_EN
  assign tick_set = tick_d;
`endif

endmodule

// File: rtl/strobe_gen.sv
// Multi-channel strobe generator: config decode, ready mux, channel array.
// Optional macro STROBE_GEN_TICK_CNT_EN adds cnt_clr and 8-bit tick_cnt per channel.
module strobe_gen
  import strobe_gen_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int DIV_W   = 16,
  parameter int RST_DIV = 0,
  parameter int RST_EN  = 0
) (
  input  logic              clk,
  input  logic              rst,
  strobe_gen_if.slave       cfg,
  input  logic              sync,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
`ifdef STROBE_GEN_TICK_CNT_EN
  ,
  input  logic                         cnt_clr,
  output logic [NUM_CH*TICK_CNT_W-1:0] tick_cnt
`endif
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              cfg_acc;
  logic [NUM_CH-1:0] cfg_wr;

  // Ready follows the addressed channel's pending flag; unknown channels accept.
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) cfg.cfg_ready = ~busy[i];
    end
  end

  assign cfg_acc = cfg.cfg_valid & cfg.cfg_ready;

  // One-hot write strobe; out-of-range channels match nothing and are dropped.
  always_comb begin
    cfg_wr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cfg_wr[i] = cfg_acc && (cfg.cfg_ch == CH_W'(i));
    end
  end

`ifdef STROBE_GEN_TICK_CNT_EN
  logic [NUM_CH-1:0] tick_set;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    strobe_gen_ch #(
      .DIV_W  (DIV_W),
      .RST_DIV(RST_DIV),
      .RST_EN (RST_EN)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .cfg_wr  (cfg_wr[g]),
      .cfg_en  (cfg.cfg_en),
      .cfg_div (cfg.cfg_div),
      .sync    (sync),
      .tick    (tick[g]),
      .busy    (busy[g])
`ifdef STROBE_GEN_TICK_CNT_EN
      ,
      .tick_set(tick_set[g])
`endif
    );
  end

`ifdef STROBE_GEN_TICK_CNT_EN
  logic [TICK_CNT_W-1:0] tick_cnt_q [NUM_CH];
  logic [TICK_CNT_W-1:0] tick_cnt_d [NUM_CH];

  // Counts advance on the edge that raises tick, so the count always equals
  // the ticks visible so far; clear beats increment.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      tick_cnt_d[i] = tick_cnt_q[i];
      if (cnt_clr)          tick_cnt_d[i] = '0;
      else if (tick_set[i]) tick_cnt_d[i] = tick_cnt_q[i] + TICK_CNT_W'(1);
    end
  end

  // Tick counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) tick_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) tick_cnt_q[i] <= tick_cnt_d[i];
    end
  end

  // Flatten counters onto the output bus, channel 0 in the low byte.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) tick_cnt[i*TICK_CNT_W +: TICK_CNT_W] = tick_cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_strobe_gen.sv
// Directed self-checking bench for strobe_gen (NUM_CH=4, DIV_W=16, RST_DIV=0, RST_EN=0).
module tb_strobe_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] tick;
  logic [3:0] busy;
  int n_checks = 0;
  int n_fail   = 0;

`ifdef STROBE_GEN_TICK_CNT_EN
  logic        cnt_clr = 1'b0;
  logic [31:0] tick_cnt;
`endif

  strobe_gen_if #(.NUM_CH(4), .DIV_W(16)) cfg_if ();

  strobe_gen #(.NUM_CH(4), .DIV_W(16), .RST_DIV(0), .RST_EN(0)) dut (
    .clk     (clk),
    .rst     (rst),
    .cfg     (cfg_if),
    .sync    (sync),
    .tick    (tick),
    .busy    (busy)
`ifdef STROBE_GEN_TICK_CNT_EN
    ,
    .cnt_clr (cnt_clr),
    .tick_cnt(tick_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cfg_if.cfg_valid = 1'b0;
    sync = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Presents one config write, waits (bounded) for ready, returns 1 ns
  // after the accepting edge.
  task automatic cfg_write(input int ch, input logic en, input logic [15:0] div);
    int w;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_en    = en;
    cfg_if.cfg_div   = div;
    cfg_if.cfg_valid = 1'b1;
    #1;
    w = 0;
    while (cfg_if.cfg_ready !== 1'b1 && w < 50) begin
      step();
      w++;
    end
    n_checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cfg_ready_wait ch%0d: ready=%b required 1", ch, cfg_if.cfg_ready);
    end
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_ch    = 2'd0;
    cfg_if.cfg_en    = 1'b0;
    cfg_if.cfg_div   = 16'd0;
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (tick !== 4'b0) begin n_fail++; $display("FAIL reset_tick: got %b required 0000", tick); end
    n_checks++;
    if (busy !== 4'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0000", busy); end
    n_checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", cfg_if.cfg_ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) step();
    n_checks++;
    if (tick !== 4'b0) begin n_fail++; $display("FAIL idle_after_reset_tick: got %b required 0000", tick); end
  endtask

  task automatic test_first_tick();
    do_reset();
    cfg_write(0, 1'b1, 16'd5);
    n_checks++;
    if (tick[0] !== 1'b0) begin n_fail++; $display("FAIL div5_accept_tick: got %b required 0", tick[0]); end
    for (int k = 1; k <= 15; k++) begin
      step();
      n_checks++;
      if (tick[0] !== ((k % 5) == 0)) begin
        n_fail++;
        $display("FAIL div5_tick k=%0d: got %b required %b", k, tick[0], (k % 5) == 0);
      end
      n_checks++;
      if (busy[0] !== 1'b0) begin n_fail++; $display("FAIL div5_busy k=%0d: got %b required 0", k, busy[0]); end
    end
  endtask

  task automatic test_shadow_update();
    do_reset();
    cfg_write(1, 1'b1, 16'd4);   // accept edge E0, cnt=3
    step();                      // cnt=2
    cfg_write(1, 1'b1, 16'd2);   // accept edge E1 with cnt=2 -> shadowed
    n_checks++;
    if (busy[1] !== 1'b1) begin n_fail++; $display("FAIL shadow_busy_set: got %b required 1", busy[1]); end
    cfg_if.cfg_ch    = 2'd1;
    cfg_if.cfg_valid = 1'b1;
    #1;
    n_checks++;
    if (cfg_if.cfg_ready !== 1'b0) begin n_fail++; $display("FAIL shadow_ready_ch1: got %b required 0", cfg_if.cfg_ready); end
    cfg_if.cfg_ch  = 2'd2;
    cfg_if.cfg_en  = 1'b1;
    cfg_if.cfg_div = 16'd3;
    #1;
    n_checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL shadow_ready_ch2: got %b required 1", cfg_if.cfg_ready); end
    step();                      // ch2 accepted at E1+1
    cfg_if.cfg_valid = 1'b0;
    n_checks++;
    if (busy[1] !== 1'b1 || tick[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL shadow_wait E1+1: busy=%b tick=%b required busy=1 tick=0", busy[1], tick[1]);
    end
    for (int k = 2; k <= 7; k++) begin
      step();
      n_checks++;
      if (tick[1] !== ((k % 2) == 0)) begin
        n_fail++;
        $display("FAIL shadow_tick1 k=%0d: got %b required %b", k, tick[1], (k % 2) == 0);
      end
      n_checks++;
      if (tick[2] !== (k == 4 || k == 7)) begin
        n_fail++;
        $display("FAIL shadow_tick2 k=%0d: got %b required %b", k, tick[2], (k == 4 || k == 7));
      end
      n_checks++;
      if (busy !== 4'b0) begin n_fail++; $display("FAIL shadow_busy_clear k=%0d: got %b required 0000", k, busy); end
    end
  endtask

  task automatic test_sync();
    logic [1:0] exp;
    do_reset();
    cfg_write(0, 1'b1, 16'd3);   // edge A
    cfg_write(1, 1'b1, 16'd7);   // edge A+1
    repeat (4) step();           // A+5: ch0 cnt=0, would tick at A+6
    sync = 1'b1;
    step();                      // sync edge S = A+6
    sync = 1'b0;
    n_checks++;
    if (tick[1:0] !== 2'b00) begin n_fail++; $display("FAIL sync_cycle_tick: got %b required 00", tick[1:0]); end
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = {k == 7, (k == 3 || k == 6)};
      n_checks++;
      if (tick[1:0] !== exp) begin
        n_fail++;
        $display("FAIL sync_tick k=%0d: got %b required %b", k, tick[1:0], exp);
      end
    end
  endtask

  task automatic test_div_zero_one();
    int seen;
    do_reset();
    cfg_write(3, 1'b1, 16'd0);
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      step();
      if (tick !== 4'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL div0_ticks: got %0d cycles with tick required 0", seen); end
    cfg_write(3, 1'b1, 16'd1);
    n_checks++;
    if (tick[3] !== 1'b0) begin n_fail++; $display("FAIL div1_accept_tick: got %b required 0", tick[3]); end
    for (int k = 1; k <= 5; k++) begin
      step();
      n_checks++;
      if (tick !== 4'b1000) begin n_fail++; $display("FAIL div1_tick k=%0d: got %b required 1000", k, tick); end
    end
  endtask

  task automatic test_reset_mid_op();
    int seen;
    do_reset();
    cfg_write(0, 1'b1, 16'd1);
    cfg_write(1, 1'b1, 16'd4);
    step();
    cfg_write(1, 1'b1, 16'd2);
    n_checks++;
    if (busy[1] !== 1'b1 || tick[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state: busy1=%b tick0=%b required 1 1", busy[1], tick[0]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (tick !== 4'b0 || busy !== 4'b0) begin
      n_fail++;
      $display("FAIL async_reset: tick=%b busy=%b required 0000 0000", tick, busy);
    end
    step();
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (tick !== 4'b0 || busy !== 4'b0) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL post_reset_idle: got %0d active cycles required 0", seen); end
    cfg_if.cfg_ch = 2'd1;
    #1;
    n_checks++;
    if (cfg_if.cfg_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b required 1", cfg_if.cfg_ready); end
  endtask

`ifdef STROBE_GEN_TICK_CNT_EN
  task automatic test_tick_cnt();
    do_reset();
    n_checks++;
    if (tick_cnt !== 32'd0) begin n_fail++; $display("FAIL tick_cnt_reset: got %h required 0", tick_cnt); end
    cfg_write(0, 1'b1, 16'd1);
    repeat (300) step();
    n_checks++;
    if (tick_cnt[7:0] !== 8'd44) begin n_fail++; $display("FAIL tick_cnt_300: got %0d required 44", tick_cnt[7:0]); end
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    n_checks++;
    if (tick[0] !== 1'b1 || tick_cnt[7:0] !== 8'd0) begin
      n_fail++;
      $display("FAIL tick_cnt_clr: tick=%b cnt=%0d required 1 0", tick[0], tick_cnt[7:0]);
    end
    step();
    n_checks++;
    if (tick_cnt !== 32'd1) begin n_fail++; $display("FAIL tick_cnt_after_clr: got %h required 1", tick_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_first_tick();
    test_shadow_update();
    test_sync();
    test_div_zero_one();
    test_reset_mid_op();
`ifdef STROBE_GEN_TICK_CNT_EN
    test_tick_cnt();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
